// File: rtl/gfx_vram_pkg.sv
// rtl/gfx_vram_pkg.sv - shared types and default geometry for the fill-capable frame buffer.
package gfx_vram_pkg;

  // Defaults describe the 320x480 mode at 8 bits per pixel.
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 153600;
  localparam int DEF_ADDR_W = 20;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/gfx_vram_dp.sv
// rtl/gfx_vram_dp.sv - simple dual-port RAM, one write port and one registered read-first read port.
module gfx_vram_dp #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]  w_widx;
  logic [IDX_W-1:0]  w_ridx;

  // Callers only write in-range addresses; out-of-range reads are don't-care.
  assign w_widx = IDX_W'(i_waddr);
  assign w_ridx = IDX_W'(i_raddr);

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[w_widx] <= i_wdata;
    end
    o_rdata <= r_mem[w_ridx];
  end

endmodule

// File: rtl/gfx_vram_fill.sv
// rtl/gfx_vram_fill.sv - frame buffer with a range fill engine that back-pressures host writes while filling.
module gfx_vram_fill
  import gfx_vram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W:0]   fill_len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              fill_busy,
  output logic              fill_ack,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_we,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W:0]   L_DEPTH   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] L_DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] L_LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   L_ONE     = (ADDR_W+1)'(1);

  fill_state_t       r_state;
  fill_state_t       w_next;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W:0]   r_cnt;
  logic [DATA_W-1:0] r_val;

  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W:0]   w_len;
  logic              w_start;
  logic              w_host_we;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  // Bases in [DEPTH, 2*DEPTH) fold back once; lengths saturate at a full frame.
  assign w_base  = ({1'b0, fill_base} >= L_DEPTH) ? (fill_base - L_DEPTH_A) : fill_base;
  assign w_len   = (fill_len > L_DEPTH) ? L_DEPTH : fill_len;
  assign w_start = (r_state == S_IDLE) && fill_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (fill_req) begin
          w_next = (w_len == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (r_cnt == L_ONE) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    fill_busy = (r_state == S_FILL);
    fill_ack  = (r_state == S_DONE);
    wr_ready  = (r_state != S_FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur <= '0;
      r_cnt <= '0;
      r_val <= '0;
    end else if (w_start) begin
      r_cur <= w_base;
      r_cnt <= w_len;
      r_val <= fill_val;
    end else if (r_state == S_FILL) begin
      r_cur <= (r_cur == L_LAST) ? '0 : (r_cur + ADDR_W'(1));
      r_cnt <= r_cnt - L_ONE;
    end
  end

  // The fill owns the write port while busy; host writes are refused then, never merged.
  always_comb begin
    w_host_we = wr_we && wr_ready && ({1'b0, wr_addr} < L_DEPTH);
    if (r_state == S_FILL) begin
      w_we    = 1'b1;
      w_waddr = r_cur;
      w_wdata = r_val;
    end else begin
      w_we    = w_host_we;
      w_waddr = wr_addr;
      w_wdata = wr_data;
    end
  end

  gfx_vram_dp #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .i_clk  (clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_raddr(rd_addr),
    .o_rdata(rd_data)
  );

endmodule

// File: tb/tb_gfx_vram_fill.sv
// tb/tb_gfx_vram_fill.sv - randomized and directed bench for gfx_vram_fill against a schedule-based memory model.
module tb_gfx_vram_fill;

  localparam int DW  = 8;
  localparam int DEP = 16;
  localparam int AW  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          fill_req;
  logic [AW-1:0] fill_base;
  logic [AW:0]   fill_len;
  logic [DW-1:0] fill_val;
  logic          fill_busy;
  logic          fill_ack;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_we;
  logic          wr_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  gfx_vram_fill #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .fill_req(fill_req), .fill_base(fill_base), .fill_len(fill_len), .fill_val(fill_val),
    .fill_busy(fill_busy), .fill_ack(fill_ack),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_we(wr_we), .wr_ready(wr_ready),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Model: a fill is a schedule (accept cycle, length, base, value), memory is a plain array.
  logic [DW-1:0] mm [DEP];
  bit            kn [DEP];
  bit            minit = 0;
  bit            act = 0;
  int            t_acc = 0;
  int            n_m = 0;
  int            mb = 0;
  logic [DW-1:0] mv = '0;
  bit            m_busy, m_ack;
  bit            rd_v = 0;
  logic [DW-1:0] rd_e = '0;
  int            widx;

  always @(negedge clk) begin
    m_busy = 0;
    m_ack  = 0;
    if (minit) begin
      m_busy = act && (cyc >= t_acc + 1) && (cyc <= t_acc + n_m);
      m_ack  = act && (cyc == t_acc + n_m + 1);
      chk("busy", 32'(fill_busy), 32'(m_busy));
      chk("ack", 32'(fill_ack), 32'(m_ack));
      chk("ready", 32'(wr_ready), 32'(!m_busy));
      if (rd_v) chk("rd_data", 32'(rd_data), 32'(rd_e));
    end
    if (int'(rd_addr) < DEP) begin
      rd_v = minit && kn[int'(rd_addr)];
      rd_e = mm[int'(rd_addr)];
    end else begin
      rd_v = 0;
    end
    if (m_busy) begin
      widx = (mb + (cyc - t_acc - 1)) % DEP;
      mm[widx] = mv;
      kn[widx] = 1;
    end else if (wr_we && int'(wr_addr) < DEP) begin
      mm[int'(wr_addr)] = wr_data;
      kn[int'(wr_addr)] = 1;
    end
    if (rst) begin
      act   = 0;
      minit = 1;
    end else if (m_ack) begin
      act = 0;
    end else if (!act && fill_req && minit) begin
      act   = 1;
      t_acc = cyc;
      n_m   = (int'(fill_len) > DEP) ? DEP : int'(fill_len);
      mb    = (int'(fill_base) >= DEP) ? int'(fill_base) - DEP : int'(fill_base);
      mv    = fill_val;
    end
  end

  bit            rd_force = 0;
  logic [AW-1:0] rd_force_addr = '0;
  always @(posedge clk) begin
    #1;
    if (rd_force) rd_addr = rd_force_addr;
    else if ($urandom_range(0, 9) == 0) rd_addr = AW'($urandom_range(DEP, 2*DEP-1));
    else rd_addr = AW'($urandom_range(0, DEP-1));
  end

  task automatic read_chk(input string nm, input int a, input logic [DW-1:0] e);
    @(negedge clk);
    rd_force_addr = AW'(a);
    rd_force = 1;
    @(negedge clk);
    @(negedge clk);
    chk(nm, 32'(rd_data), 32'(e));
    rd_force = 0;
  endtask

  task automatic host_write(input int a, input logic [DW-1:0] d, output int stalls);
    bit ok;
    @(posedge clk); #1;
    wr_we = 1; wr_addr = AW'(a); wr_data = d;
    stalls = 0;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (wr_ready) ok = 1;
      else stalls++;
    end
    if (!ok) chk("wr_timeout", 0, 1);
    @(posedge clk); #1;
    wr_we = 0;
  endtask

  task automatic do_fill(input int b, input int l, input logic [DW-1:0] v, output int lat, output int nb);
    int t0;
    bit done;
    @(posedge clk); #1;
    fill_req = 1; fill_base = AW'(b); fill_len = (AW+1)'(l); fill_val = v;
    @(negedge clk);
    t0 = cyc; lat = -1; nb = 0; done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(posedge clk); #1;
      fill_base = AW'($urandom); fill_len = (AW+1)'($urandom); fill_val = DW'($urandom);
      @(negedge clk);
      if (fill_busy) nb++;
      if (fill_ack) begin lat = cyc - t0; done = 1; end
    end
    if (!done) chk("fill_timeout", 0, 1);
    @(posedge clk); #1;
    fill_req = 0;
  endtask

  int lat, nb, st0, st1, rb, rl, rdly, kind, nexp;
  logic [DW-1:0] rv;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; fill_req = 0; fill_base = '0; fill_len = '0; fill_val = '0;
    wr_we = 0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_busy", 32'(fill_busy), 0);
    chk("reset_ack", 32'(fill_ack), 0);
    chk("reset_ready", 32'(wr_ready), 1);

    for (int a = 0; a < DEP; a++) host_write(a, DW'(8'h40 + a), st0);
    read_chk("preload_7", 7, 8'h47);

    host_write(7, 8'h11, st0);
    @(negedge clk);
    rd_force_addr = 5'd7; rd_force = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rd_latency", 32'(rd_data), 32'h11);
    @(posedge clk); #1;
    wr_we = 1; wr_addr = 5'd7; wr_data = 8'h22;
    @(posedge clk); #1;
    wr_we = 0;
    @(negedge clk);
    chk("rd_read_first", 32'(rd_data), 32'h11);
    @(negedge clk);
    chk("rd_after_write", 32'(rd_data), 32'h22);
    rd_force = 0;

    do_fill(14, 4, 8'hA5, lat, nb);
    chk("wrap_ack_latency", lat, 5);
    chk("wrap_busy_cycles", nb, 4);
    read_chk("wrap_14", 14, 8'hA5);
    read_chk("wrap_15", 15, 8'hA5);
    read_chk("wrap_0", 0, 8'hA5);
    read_chk("wrap_1", 1, 8'hA5);
    read_chk("wrap_2_kept", 2, 8'h42);
    read_chk("wrap_13_kept", 13, 8'h4D);

    do_fill(3, 0, 8'hEE, lat, nb);
    chk("zero_ack_latency", lat, 1);
    chk("zero_busy_cycles", nb, 0);
    read_chk("zero_3_kept", 3, 8'h43);

    fork
      begin do_fill(2, 8, 8'h77, lat, nb); end
      begin
        host_write(3, 8'h99, st0);
        @(posedge clk); @(posedge clk);
        host_write(5, 8'h3C, st1);
      end
    join
    chk("coll_ack_latency", lat, 9);
    chk("coll_accept_cycle_no_stall", st0, 0);
    chk("coll_stalled", 32'(st1 > 0), 1);
    read_chk("coll_5_held_write", 5, 8'h3C);
    read_chk("coll_3_overwritten", 3, 8'h77);

    do_fill(20, 40, 8'h03, lat, nb);
    chk("clamp_ack_latency", lat, 17);
    chk("clamp_busy_cycles", nb, 16);
    read_chk("clamp_0", 0, 8'h03);
    read_chk("clamp_4", 4, 8'h03);

    for (int a = 0; a < DEP; a++) host_write(a, DW'($urandom), st0);
    do_fill(0, 16, 8'h00, lat, nb);
    chk("clear_ack_latency", lat, 17);
    chk("clear_busy_cycles", nb, 16);
    for (int a = 0; a < DEP; a++) read_chk("clear_read", a, 8'h00);

    for (int a = 0; a < DEP; a++) host_write(a, DW'(8'h40 + a), st0);
    @(posedge clk); #1;
    fill_req = 1; fill_base = '0; fill_len = 6'd16; fill_val = 8'h5A;
    @(negedge clk);
    repeat (10) @(posedge clk);
    #1 rst = 1; fill_req = 0;
    @(negedge clk);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("midrst_busy", 32'(fill_busy), 0);
    chk("midrst_ack", 32'(fill_ack), 0);
    for (int a = 0; a < 10; a++) read_chk("midrst_filled", a, 8'h5A);
    for (int a = 10; a < DEP; a++) read_chk("midrst_kept", a, DW'(8'h40 + a));
    do_fill(6, 3, 8'hC3, lat, nb);
    chk("midrst_refill_latency", lat, 4);
    read_chk("midrst_refill_7", 7, 8'hC3);

    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        rb   = $urandom_range(0, 2*DEP-1);
        rl   = ($urandom_range(0, 7) == 0) ? 40 : $urandom_range(0, 18);
        rv   = DW'($urandom);
        rdly = $urandom_range(0, 6);
        fork
          begin do_fill(rb, rl, rv, lat, nb); end
          begin
            repeat (rdly) @(posedge clk);
            host_write($urandom_range(0, 2*DEP-1), DW'($urandom), st0);
          end
        join
        nexp = (rl > DEP) ? DEP : rl;
        chk("rnd_ack_latency", lat, nexp + 1);
        chk("rnd_busy_cycles", nb, nexp);
      end else if (kind == 1) begin
        host_write($urandom_range(0, 2*DEP-1), DW'($urandom), st0);
      end else begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
      end
    end
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
